// File: rtl/dmem_wbuf_responder.sv
// Data-memory responder: single-cycle local word array plus a write-through
// buffer that drains every accepted store to external memory over req/ack.
module dmem_wbuf_responder #(
    parameter int ADDR_W   = 8,
    parameter int WB_DEPTH = 4,
    parameter int CNT_W    = $clog2(WB_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_wen_D,
    input  logic [29:0]      mem_addr_D,
    input  logic [63:0]      mem_wdata_D,
    output logic [63:0]      mem_rdata_D,
    output logic             stall_D,
    output logic             ext_req,
    output logic [29:0]      ext_addr,
    output logic [63:0]      ext_wdata,
    input  logic             ext_ack,
    output logic [CNT_W-1:0] wb_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } drain_state_e;

    logic [63:0]      mem_r       [DEPTH];
    logic [29:0]      fifo_addr_r [WB_DEPTH];
    logic [63:0]      fifo_data_r [WB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    drain_state_e     state_r;
    drain_state_e     next_state_s;
    logic             ext_req_r;
    logic [29:0]      ext_addr_r;
    logic [63:0]      ext_wdata_r;
    logic [ADDR_W-1:0] idx_s;
    logic             stall_s;
    logic             push_s;
    logic             pop_s;
    logic             load_s;

    // Stall looks only at the registered count, so a same-cycle pop does not release it
    assign idx_s       = mem_addr_D[ADDR_W-1:0];
    assign stall_s     = mem_wen_D & (count_r == FULL_CNT);
    assign push_s      = mem_wen_D & ~stall_s;
    assign mem_rdata_D = mem_r[idx_s];
    assign stall_D     = stall_s;
    assign ext_req     = ext_req_r;
    assign ext_addr    = ext_addr_r;
    assign ext_wdata   = ext_wdata_r;
    assign wb_count    = count_r;

    // Local word array: cleared on reset, written by every accepted store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'h0;
            end
        end else if (push_s) begin
            mem_r[idx_s] <= mem_wdata_D;
        end
    end

    // Write-buffer storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                fifo_addr_r[i] <= 30'h0;
                fifo_data_r[i] <= 64'h0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= mem_addr_D;
                fifo_data_r[wr_ptr_r] <= mem_wdata_D;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Drain FSM next state; the head entry is popped only once it is acknowledged
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    load_s       = 1'b1;
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ext_ack) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // External request registers, held stable for the whole BUSY phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_req_r   <= 1'b0;
            ext_addr_r  <= 30'h0;
            ext_wdata_r <= 64'h0;
        end else if (load_s) begin
            ext_req_r   <= 1'b1;
            ext_addr_r  <= fifo_addr_r[rd_ptr_r];
            ext_wdata_r <= fifo_data_r[rd_ptr_r];
        end else if (pop_s) begin
            ext_req_r   <= 1'b0;
        end else begin
            ext_req_r   <= ext_req_r;
        end
    end
endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Self-checking bench for dmem_wbuf_responder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dmem_wbuf_responder;
    localparam int ADDR_W   = 8;
    localparam int WB_DEPTH = 4;
    localparam int CNT_W    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_wen_D;
    logic [29:0]      mem_addr_D;
    logic [63:0]      mem_wdata_D;
    logic [63:0]      mem_rdata_D;
    logic             stall_D;
    logic             ext_req;
    logic [29:0]      ext_addr;
    logic [63:0]      ext_wdata;
    logic             ext_ack;
    logic [CNT_W-1:0] wb_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [29:0] a;
        logic [63:0] d;
    } ent_t;

    // Reference model: word array, queue of not-yet-acknowledged stores, current request
    logic [63:0] mdl_mem [256];
    ent_t        mdl_q [$];
    bit          mdl_req;
    ent_t        mdl_cur;

    dmem_wbuf_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_wen_D(mem_wen_D), .mem_addr_D(mem_addr_D), .mem_wdata_D(mem_wdata_D),
        .mem_rdata_D(mem_rdata_D), .stall_D(stall_D),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 64'h0;
        mdl_q.delete();
        mdl_req = 1'b0;
        mdl_cur = '0;
    endtask

    // Advance one clock; update the model with the inputs seen at the edge, return at negedge
    task automatic tick();
        ent_t e;
        bit   stall;
        @(posedge clk);
        stall = mem_wen_D && (mdl_q.size() == WB_DEPTH);
        if (mdl_req) begin
            if (ext_ack) begin
                mdl_req = 1'b0;
                void'(mdl_q.pop_front());
            end
        end else if (mdl_q.size() > 0) begin
            mdl_req = 1'b1;
            mdl_cur = mdl_q[0];
        end
        if (mem_wen_D && !stall) begin
            e.a = mem_addr_D;
            e.d = mem_wdata_D;
            mdl_q.push_back(e);
            mdl_mem[mem_addr_D[7:0]] = mem_wdata_D;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        mem_wen_D = 1'b0; mem_addr_D = 30'h0; mem_wdata_D = 64'h0; ext_ack = 1'b0;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        mem_addr_D = 30'h5;
        mem_wen_D  = 1'b1;
        #1;
        n_vec++; if (mem_rdata_D !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata_D); end
        n_vec++; if (ext_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", ext_req); end
        n_vec++; if (wb_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", wb_count); end
        n_vec++; if (stall_D !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_D); end
        mem_wen_D = 1'b0;
    endtask

    task automatic test_single_store();
        reset_dut();
        mem_wen_D = 1'b1; mem_addr_D = 30'h5; mem_wdata_D = 64'h1122334455667788;
        tick();
        mem_wen_D = 1'b0;
        n_vec++; if (mem_rdata_D !== 64'h1122334455667788) begin n_err++; $display("FAIL single_rdata: got %h expected 1122334455667788", mem_rdata_D); end
        n_vec++; if (wb_count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d expected 1", wb_count); end
        n_vec++; if (ext_req !== 1'b0) begin n_err++; $display("FAIL single_req_early: got %b expected 0", ext_req); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (ext_req !== 1'b1 || ext_addr !== 30'h5 || ext_wdata !== 64'h1122334455667788) begin
                n_err++;
                $display("FAIL single_hold%0d: got req=%b addr=%h data=%h expected req=1 addr=5 data=1122334455667788", i, ext_req, ext_addr, ext_wdata);
            end
        end
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        n_vec++; if (wb_count !== 3'd0 || ext_req !== 1'b0) begin n_err++; $display("FAIL single_ack: got count=%0d req=%b expected 0 0", wb_count, ext_req); end
    endtask

    task automatic test_full_stall();
        reset_dut();
        for (int i = 1; i <= 4; i++) begin
            mem_wen_D = 1'b1; mem_addr_D = 30'(i); mem_wdata_D = 64'(8'hA0 + i);
            tick();
        end
        mem_addr_D = 30'h5; mem_wdata_D = 64'hA5;
        #1;
        n_vec++; if (wb_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d expected 4", wb_count); end
        n_vec++; if (stall_D !== 1'b1) begin n_err++; $display("FAIL full_stall: got %b expected 1", stall_D); end
        n_vec++; if (ext_req !== 1'b1 || ext_addr !== 30'h1 || ext_wdata !== 64'hA1) begin n_err++; $display("FAIL full_head: got req=%b addr=%h data=%h expected 1 1 a1", ext_req, ext_addr, ext_wdata); end
        tick();
        n_vec++; if (mem_rdata_D !== 64'h0 || wb_count !== 3'd4) begin n_err++; $display("FAIL stalled_store: got rdata=%h count=%0d expected 0 4", mem_rdata_D, wb_count); end
        ext_ack = 1'b1;
        #1;
        n_vec++; if (stall_D !== 1'b1) begin n_err++; $display("FAIL stall_pop_pending: got %b expected 1", stall_D); end
        tick();
        ext_ack = 1'b0;
        n_vec++; if (wb_count !== 3'd3 || mem_rdata_D !== 64'h0 || stall_D !== 1'b0) begin n_err++; $display("FAIL after_pop: got count=%0d rdata=%h stall=%b expected 3 0 0", wb_count, mem_rdata_D, stall_D); end
        tick();
        mem_wen_D = 1'b0;
        #1;
        n_vec++; if (mem_rdata_D !== 64'hA5 || wb_count !== CNT_W'(mdl_q.size())) begin n_err++; $display("FAIL retry_accept: got rdata=%h count=%0d expected a5 %0d", mem_rdata_D, wb_count, mdl_q.size()); end
    endtask

    task automatic test_ordering();
        ent_t obs [$];
        ent_t exp [$];
        bit   prev_req;
        int   stores;
        reset_dut();
        ext_ack = 1'b1;
        exp.push_back({30'h10, 64'hB0});
        exp.push_back({30'h11, 64'hB1});
        exp.push_back({30'h10, 64'hB2});
        prev_req = 1'b0;
        stores = 0;
        for (int c = 0; c < 20; c++) begin
            if (stores < 3) begin
                mem_wen_D = 1'b1; mem_addr_D = exp[stores].a; mem_wdata_D = exp[stores].d;
                stores++;
            end else begin
                mem_wen_D = 1'b0; mem_addr_D = 30'h10;
            end
            tick();
            if (ext_req) begin
                n_vec++;
                if (prev_req) begin n_err++; $display("FAIL order_gap: got back-to-back request at cycle %0d expected a 1-cycle gap", c); end
                obs.push_back({ext_addr, ext_wdata});
            end
            prev_req = ext_req;
        end
        n_vec++; if (obs.size() != 3) begin n_err++; $display("FAIL order_count: got %0d writes expected 3", obs.size()); end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            n_vec++;
            if (obs[i] !== exp[i]) begin n_err++; $display("FAIL order_%0d: got addr=%h data=%h expected addr=%h data=%h", i, obs[i].a, obs[i].d, exp[i].a, exp[i].d); end
        end
        n_vec++; if (mem_rdata_D !== 64'hB2) begin n_err++; $display("FAIL order_rdata: got %h expected b2", mem_rdata_D); end
        ext_ack = 1'b0;
    endtask

    task automatic test_alias();
        reset_dut();
        mem_wen_D = 1'b1; mem_addr_D = 30'h105; mem_wdata_D = 64'hC0;
        tick();
        mem_wen_D = 1'b0; mem_addr_D = 30'h005;
        #1;
        n_vec++; if (mem_rdata_D !== 64'hC0) begin n_err++; $display("FAIL alias_rdata: got %h expected c0", mem_rdata_D); end
        tick();
        n_vec++; if (ext_req !== 1'b1 || ext_addr !== 30'h105) begin n_err++; $display("FAIL alias_ext: got req=%b addr=%h expected 1 105", ext_req, ext_addr); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            mem_wen_D = 1'b1; mem_addr_D = 30'(32 + i); mem_wdata_D = 64'(8'hD0 + i);
            tick();
        end
        mem_wen_D = 1'b0; mem_addr_D = 30'h21;
        #1;
        n_vec++; if (ext_req !== 1'b1 || wb_count !== 3'd3 || mem_rdata_D !== 64'hD1) begin n_err++; $display("FAIL pre_reset: got req=%b count=%0d rdata=%h expected 1 3 d1", ext_req, wb_count, mem_rdata_D); end
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        n_vec++; if (ext_req !== 1'b0 || wb_count !== 3'd0 || mem_rdata_D !== 64'h0) begin n_err++; $display("FAIL mid_reset: got req=%b count=%0d rdata=%h expected 0 0 0", ext_req, wb_count, mem_rdata_D); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++; if (ext_req !== 1'b0 || wb_count !== 3'd0) begin n_err++; $display("FAIL stale_req%0d: got req=%b count=%0d expected 0 0", i, ext_req, wb_count); end
        end
    endtask

    task automatic test_random();
        bit exp_stall;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            mem_wen_D   = ($urandom_range(0, 9) < 6);
            mem_addr_D  = {20'($urandom), 6'd0, 4'($urandom_range(0, 15))};
            mem_wdata_D = {$urandom, $urandom};
            ext_ack     = ($urandom_range(0, 1) == 1);
            #1;
            exp_stall = mem_wen_D && (mdl_q.size() == WB_DEPTH);
            n_vec++; if (mem_rdata_D !== mdl_mem[mem_addr_D[7:0]]) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c, mem_rdata_D, mdl_mem[mem_addr_D[7:0]]); end
            n_vec++; if (stall_D !== exp_stall) begin n_err++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, stall_D, exp_stall); end
            tick();
            n_vec++;
            if (ext_req !== mdl_req || ext_addr !== mdl_cur.a || ext_wdata !== mdl_cur.d || wb_count !== CNT_W'(mdl_q.size())) begin
                n_err++;
                $display("FAIL rnd_ext c%0d: got req=%b addr=%h data=%h count=%0d expected req=%b addr=%h data=%h count=%0d",
                         c, ext_req, ext_addr, ext_wdata, wb_count, mdl_req, mdl_cur.a, mdl_cur.d, mdl_q.size());
            end
        end
        mem_wen_D = 1'b0;
        ext_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_wen_D = 1'b0; mem_addr_D = 30'h0; mem_wdata_D = 64'h0; ext_ack = 1'b0;
        model_clear();
        test_reset();
        test_single_store();
        test_full_stall();
        test_ordering();
        test_alias();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_wbuf_responder.md
Name: dmem_wbuf_responder

Overview:
- Responder on the CPU data-memory port: it serves the mem_wen_D / mem_addr_D / mem_wdata_D / mem_rdata_D requests the single-cycle core issues.
- Holds a local 64-bit word array, so reads complete in the same cycle.
- Every accepted store is also queued in a write-through buffer. The buffer drains to a slower external memory over a req/ack handshake.
- stall_D is the back-pressure signal the next core revision consumes.

Parameters:
- ADDR_W, 8, local array index width (DEPTH = 2**ADDR_W words of 64 bits).
- WB_DEPTH, 4, write-buffer entries; must be a power of two and at least 2.
- CNT_W, $clog2(WB_DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_wen_D  in  1  store request this cycle.
- mem_addr_D  in  30  word address (byte address bits 31:2).
- mem_wdata_D  in  64  store data, stored and forwarded unmodified (no byte reordering).
- mem_rdata_D  out  64  read data, combinational.
- stall_D  out  1  store cannot be accepted this cycle; the core must hold the request.
- ext_req  out  1  external write request, registered.
- ext_addr  out  30  external word address, registered.
- ext_wdata  out  64  external write data, registered.
- ext_ack  in  1  external memory accepted the current request.
- wb_count  out  CNT_W  write-buffer occupancy, registered.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - all array words 0;
  - FIFO read/write pointers 0, wb_count 0;
  - ext_req 0, ext_addr 0, ext_wdata 0;
  - drain FSM in IDLE.
- Index: idx = mem_addr_D[ADDR_W-1:0]. Upper address bits are ignored for the local array, so addresses alias modulo DEPTH. The full 30-bit address is queued and sent externally.
- Read path:
  - mem_rdata_D = array[idx], combinational, every cycle, independent of mem_wen_D.
  - A store is visible on mem_rdata_D from the cycle after the accepting edge.
- Stall: stall_D = mem_wen_D AND (wb_count == WB_DEPTH). It is combinational and uses only the registered count, so a pop in the same cycle does not clear it.
- Store accept: at a rising edge with mem_wen_D=1 and stall_D=0:
  - array[idx] <= mem_wdata_D;
  - {mem_addr_D, mem_wdata_D} pushed at the FIFO tail.
- Stalled store: changes neither the array nor the FIFO.
- Count update: wb_count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Pointers wrap modulo WB_DEPTH.
- Drain FSM, IDLE:
  - if FIFO not empty, ext_addr/ext_wdata <= head entry, ext_req <= 1, go to BUSY;
  - else stay, ext_req stays 0.
- Drain FSM, BUSY:
  - ext_req, ext_addr and ext_wdata are held stable;
  - if ext_ack=1 at the edge: pop head, ext_req <= 0, go to IDLE;
  - else stay.
  - Maximum drain rate is one entry per 2 cycles, with a mandatory one-cycle ext_req=0 bubble between requests.
- ext_ack while in IDLE is ignored.
- Ordering: external writes leave strictly in acceptance order. Stores to the same address are all sent, with no merging.
- Empty FIFO to first request: a store accepted at edge N gives ext_req=1 after edge N+1, provided the FSM was in IDLE with the FIFO empty.
- Full FIFO with a pop pending: the store stalls this cycle and is accepted the next cycle.
- Reset mid-transaction: ext_req drops immediately (asynchronous); queued entries are discarded; the array is cleared.

Test Plan:
1. Reset, then read addr 0x05 -> mem_rdata_D=0, ext_req=0, wb_count=0, stall_D=0.
2. Store 0x1122334455667788 to addr 0x05 with ext_ack=0 -> next cycle mem_rdata_D at 0x05 = 0x1122334455667788, wb_count=1. One cycle later ext_req=1, ext_addr=0x05, ext_wdata=0x1122334455667788, and these stay stable until ext_ack is pulsed; then wb_count=0 and ext_req=0.
3. ext_ack held 0, four stores to addrs 1..4 with data 0xA1..0xA4 -> wb_count=4. A fifth store (addr 5, data 0xA5) sees stall_D=1, array[5] stays 0, count stays 4. Pulse ext_ack: 0xA1 pops. The fifth store is accepted the cycle after the pop.
4. ext_ack tied 1, stores to addrs 0x10, 0x11, 0x10 with data 0xB0, 0xB1, 0xB2 -> external writes appear in order (0x10,0xB0), (0x11,0xB1), (0x10,0xB2), each request 1 cycle long with a 1-cycle gap. Final mem_rdata_D at 0x10 = 0xB2.
5. Aliasing: store 0xC0 to addr 0x105 with ADDR_W=8 -> mem_rdata_D at addr 0x005 = 0xC0, and ext_addr=0x105.
6. Assert rst while ext_req=1 and wb_count=3 -> ext_req=0, wb_count=0 and array reads 0 immediately. After release, no stale external request appears.
